// File: rtl/csr_intr_pkg.sv
// rtl/csr_intr_pkg.sv - shared types and constants for the machine-mode interrupt controller
// Purpose: FSM state encoding, mtvec mode codes and the mcause interrupt flag.
// Ports: none (package).
package csr_intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } intr_state_e;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;
    localparam logic       MCAUSE_INTR_BIT     = 1'b1;

endpackage

// File: rtl/csr_irq_prio_enc.sv
// rtl/csr_irq_prio_enc.sv - combinational lowest-index-first priority encoder
// Purpose: pick the lowest set request bit.
// Ports:
//   req_i   in  N     request vector
//   valid_o out 1     any request set
//   id_o    out ID_W  index of the lowest set bit (0 when none)
module csr_irq_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req_i,
    output logic            valid_o,
    output logic [ID_W-1:0] id_o
);

    always_comb begin
        valid_o = |req_i;
        id_o    = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/csr_intr_ctrl.sv
// rtl/csr_intr_ctrl.sv - machine-mode interrupt controller between CSR file and PC mux
// Purpose: latch interrupt sources into pending bits, gate with mie/mstatus.MIE, pick the
// lowest-index winner and run the trap request/ack handshake until mret.
// Optional feature macro: CSR_IRQ_SYNC_EN adds a 2-flop synchronizer on every irq_i bit.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   irq_i            raw interrupt lines
//   mstatus_mie_i    global interrupt enable
//   mie_i            per-source enables
//   mtvec_i          trap vector base + mode in [1:0]
//   mepc_i           mret return address
//   is_mret_i        mret retiring this cycle
//   trap_ack_i       pipeline committed the trap
//   pend_clr_i       software clear of edge pending bits
//   mip_o            pending bits
//   trap_req_o       trap request
//   trap_pc_o        handler target while requesting, else 0
//   trap_cause_o     mcause value while requesting, else 0
//   redirect_pc_o    mepc_i on mret, else trap_pc_o
//   in_handler_o     high from ack until mret
module csr_intr_ctrl
    import csr_intr_pkg::*;
#(
    parameter int                   DW        = 32,
    parameter int                   NUM_IRQ   = 4,
    parameter int                   IRQ_BASE  = 16,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               mstatus_mie_i,
    input  logic [NUM_IRQ-1:0] mie_i,
    input  logic [DW-1:0]      mtvec_i,
    input  logic [DW-1:0]      mepc_i,
    input  logic               is_mret_i,
    input  logic               trap_ack_i,
    input  logic [NUM_IRQ-1:0] pend_clr_i,
    output logic [NUM_IRQ-1:0] mip_o,
    output logic               trap_req_o,
    output logic [DW-1:0]      trap_pc_o,
    output logic [DW-1:0]      trap_cause_o,
    output logic [DW-1:0]      redirect_pc_o,
    output logic               in_handler_o
);

    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] rise, clr_mask, ack_mask, eligible;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    intr_state_e        state_q;
    logic [ID_W-1:0]    id_q;
    logic               trap_req_q, in_handler_q;
    logic [DW-1:0]      base, code, target;

`ifdef CSR_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_i;
`endif

    assign rise     = irq_s & ~irq_prev_q;
    assign ack_mask = (state_q == REQ && trap_ack_i) ? (NUM_IRQ'(1) << id_q) : '0;
    assign clr_mask = pend_clr_i | ack_mask;

    // Edge bits hold until cleared (a new rising edge beats a clear); level bits follow the line.
    assign pend_d = (EDGE_MASK & ((pend_q & ~clr_mask) | rise)) | (~EDGE_MASK & irq_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
            pend_q     <= '0;
        end else begin
            irq_prev_q <= irq_s;
            pend_q     <= pend_d;
        end
    end

    assign eligible = pend_q & mie_i & {NUM_IRQ{mstatus_mie_i}};

    csr_irq_prio_enc #(
        .N    (NUM_IRQ),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req_i   (eligible),
        .valid_o (win_valid),
        .id_o    (win_id)
    );

    // Once in REQ the request is committed: enables or sources dropping do not withdraw it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            id_q         <= '0;
            trap_req_q   <= 1'b0;
            in_handler_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q    <= REQ;
                        id_q       <= win_id;
                        trap_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (trap_ack_i) begin
                        state_q      <= HANDLER;
                        trap_req_q   <= 1'b0;
                        in_handler_q <= 1'b1;
                    end
                end
                HANDLER: begin
                    if (is_mret_i) begin
                        state_q      <= IDLE;
                        in_handler_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    trap_req_q   <= 1'b0;
                    in_handler_q <= 1'b0;
                end
            endcase
        end
    end

    assign base   = {mtvec_i[DW-1:2], 2'b00};
    assign code   = DW'(IRQ_BASE) + DW'(id_q);
    // Reserved modes 2/3 fall back to direct.
    assign target = (mtvec_i[1:0] == MTVEC_MODE_VECTORED) ? base + (code << 2) : base;

    assign mip_o         = pend_q;
    assign trap_req_o    = trap_req_q;
    assign in_handler_o  = in_handler_q;
    assign trap_pc_o     = trap_req_q ? target : '0;
    assign trap_cause_o  = trap_req_q ? {MCAUSE_INTR_BIT, code[DW-2:0]} : '0;
    assign redirect_pc_o = is_mret_i ? mepc_i : trap_pc_o;

endmodule
